// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory program loader:
// FSM state encoding and the byte counts of the header and of one word.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_DATA = 3'd1,
    ST_CHK  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } loader_state_e;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/byte_packer.sv
// Packs a stream of bytes little-endian into 32-bit words. The first byte
// of a word lands in bits 7:0. word_valid_o pulses combinationally in the
// cycle the last byte of a word is accepted, with word_o carrying that word.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam logic [1:0] LANE_LAST = 2'(WORD_BYTES - 1);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] shift_q, shift_d;

  // New bytes enter at the top so that after a full word the oldest byte
  // sits in the least significant lane.
  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    if (clear_i) begin
      lane_d  = '0;
      shift_d = '0;
    end else if (byte_valid_i) begin
      lane_d  = lane_q + 2'd1;
      shift_d = {byte_i, shift_q[31:8]};
    end
  end

  // Lane position and partial word registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
    end
  end

  assign word_valid_o = byte_valid_i && (lane_q == LANE_LAST);
  assign word_o       = {byte_i, shift_q[31:8]};

endmodule

// File: rtl/insn_mem_loader.sv
// Hardware program loader. Receives a length-prefixed byte image over a
// valid/ready stream and writes it word by word into instruction memory
// from address 0, holding the core in reset until the image is complete.
// Optional trailing checksum byte: define LOADER_CHECKSUM_EN.
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on the registered state, never on in_valid.
module insn_mem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e ST_AFTER_DATA = ST_CHK;
`else
  localparam loader_state_e ST_AFTER_DATA = ST_DONE;
`endif

  localparam logic [ADDR_W:0] CNT_ONE   = 1;
  localparam logic [31:0]     DEPTH_W32 = 32'(DEPTH);

  loader_state_e     state_q, state_d;
  logic [31:0]       count_q, count_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [ADDR_W:0]   word_cnt_inc;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  logic        accept;
  logic        pack_en;
  logic        pack_clear;
  logic        pack_word_valid;
  logic [31:0] pack_word;

  assign accept       = in_valid && in_ready;
  assign word_cnt_inc = word_cnt_q + CNT_ONE;

  // The header count and the data words share one packer.
  byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (pack_clear),
    .byte_valid_i (pack_en),
    .byte_i       (in_data),
    .word_valid_o (pack_word_valid),
    .word_o       (pack_word)
  );

  // Next-state logic: header decode, word writes, end-of-image and re-arm.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_cnt_d  = word_cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pack_en     = 1'b0;
    pack_clear  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      ST_HDR: begin
        pack_en = accept;
        if (pack_word_valid) begin
          count_d    = pack_word;
          word_cnt_d = '0;
          // Full 32-bit compare so that huge counts cannot alias into range.
          if (pack_word > DEPTH_W32) state_d = ST_ERR;
          else if (pack_word == 32'd0) state_d = ST_AFTER_DATA;
          else state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        pack_en = accept;
`ifdef LOADER_CHECKSUM_EN
        if (accept) sum_d = sum_q + in_data;
`endif
        if (pack_word_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = word_cnt_q[ADDR_W-1:0];
          mem_wdata_d = pack_word;
          word_cnt_d  = word_cnt_inc;
          if (32'(word_cnt_inc) == count_q) state_d = ST_AFTER_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (accept) begin
          if ((sum_q + in_data) == 8'h00) state_d = ST_DONE;
          else state_d = ST_ERR;
        end
      end
`endif
      ST_DONE, ST_ERR: begin
        if (restart) begin
          state_d    = ST_HDR;
          count_d    = '0;
          word_cnt_d = '0;
          pack_clear = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
        end
      end
      default: state_d = ST_HDR;
    endcase
  end

  // State and datapath registers; reset drops any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HDR;
      count_q     <= '0;
      word_cnt_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      word_cnt_q  <= word_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CHK);
  assign core_hold = (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERR);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/insn_mem_loader.md
Name: insn_mem_loader

Overview:
- Hardware program loader; the on-chip counterpart of the bench's `$readmemh` image load.
- Accepts a byte stream (valid/ready) carrying a length-prefixed program image.
- Packs bytes little-endian into 32-bit words and writes them sequentially into instruction memory from word 0.
- Holds the core in reset until the image is fully written.

Parameters:
- DEPTH, 1024, instruction memory depth in words
- ADDR_W, 10, word-address width; must equal clog2(DEPTH)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts byte this cycle
- restart  input  1  single-cycle pulse; re-arms the loader from DONE/ERR
- mem_we  output  1  instruction memory write strobe
- mem_addr  output  ADDR_W  word address for the write
- mem_wdata  output  32  word to write
- core_hold  output  1  high keeps the core in reset
- done  output  1  image loaded successfully
- error  output  1  load aborted

Behaviour:
- Byte accepted on a rising edge when in_valid && in_ready.
- Frame format: 4-byte word count N (little-endian), then 4*N data bytes; each word is little-endian (first byte → bits 7:0).
- States:
  - HDR: collect 4 count bytes. After the 4th byte:
    - N > DEPTH → ERR.
    - N == 0 → DONE (or CHK when the optional feature is enabled).
    - otherwise → DATA.
  - DATA: collect 4 bytes per word; mem_we pulses for exactly one cycle, registered, in the cycle after the 4th byte is accepted. mem_addr = word index (0..N-1); mem_wdata = assembled word.
    - After word N-1 is accepted → DONE (or CHK).
    - in_ready stays high in DATA; the write cycle does not stall the stream. mem_addr/mem_wdata remain valid while mem_we is high.
  - DONE: in_ready=0, done=1, core_hold=0.
  - ERR: in_ready=0, error=1, core_hold=1; no further mem_we.
- Outputs during the load states:
  - in_ready=1 in HDR/DATA/CHK.
  - core_hold=1 in every state except DONE.
  - The final mem_we pulse may coincide with the first DONE cycle.
- restart:
  - In DONE or ERR → HDR, counters and byte lane cleared, core_hold=1 next cycle.
  - Ignored in HDR/DATA/CHK.
- Reset (synchronous, also mid-frame):
  - Next state HDR, byte lane/word counter/count cleared.
  - Outputs after reset: mem_we=0, mem_addr=0, mem_wdata=0, done=0, error=0, core_hold=1, in_ready=1.
  - A pending write is dropped.
- Width rules:
  - Count register is 32 bits; comparison against DEPTH is done at full width, so counts ≥ 2^ADDR_W+1 are caught.
  - Word counter is ADDR_W+1 bits and never wraps, because N ≤ DEPTH.
- in_valid low mid-word: the byte lane holds its position indefinitely; there is no timeout.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - After the data bytes, state CHK accepts one byte.
  - The 8-bit sum (mod 256) of all data bytes plus this byte must be 0x00: DONE if so, otherwise ERR.
  - The header bytes are excluded from the sum.
  - The sum accumulator resets with reset/restart.
- Undefined: no CHK state; the loader goes to DONE directly after the last word or after N==0.

Decomposition:
- Package loader_pkg:
  - state encoding (HDR, DATA, CHK, DONE, ERR)
  - HDR_BYTES=4
  - WORD_BYTES=4
- Sub-module byte_packer:
  - 2-bit lane counter plus 32-bit shift/insert register.
  - Asserts word_valid for one cycle with the packed word when the 4th byte is accepted.
  - Shared by the HDR (count) and DATA phases.

Test Plan:
- Feature off; stream 01 00 00 00, 13 05 10 00 → one write at addr 0 with data 0x00100513. done=1 and core_hold=0 in the cycle after the write; in_ready=0 afterwards.
- N=3, in_valid toggled every other cycle → writes at addr 0,1,2 with the correct words, each mem_we exactly one cycle; no write while in_valid is low.
- Header 01 04 00 00 (N=1025 > 1024) → error=1, core_hold=1, no mem_we. restart pulse then N=0 → done=1 with zero writes.
- Reset asserted after 6 of 8 data bytes → all outputs at reset values next cycle. A fresh frame N=1 then writes addr 0 (not addr 1).
- LOADER_CHECKSUM_EN defined, N=1, data 01 02 03 04, checksum 0xF6 → done. Same frame with checksum 0xF5 → error, word still written at addr 0.
- N=1024 full image of the incrementing pattern (word k = k) → last write addr 0x3FF data 0x000003FF, then done. Readback of mem[0..1023] matches.
